plant_sprite_fetch: RTL
=======================

# plant_sprite_fetch

Per-pixel sprite fetch stage for the lawn's plants, sitting directly upstream of the 7-bit-index plant sprite palette. It takes the VGA controller's draw coordinates and decides which lawn cell and plant type cover that pixel. It then drives a synchronous sprite-sheet ROM and delivers a registered palette index plus an opaque flag to the palette and compositor. It also holds the 5×9 lawn occupancy map and the global plant animation-frame counter.

## Interface
Parameters:
- GRID_X0, 40: left pixel of lawn cell column 0
- GRID_Y0, 80: top pixel of lawn cell row 0
- ANIM_DIV, 15: video frames per animation step
- NUM_FRAMES, 2: animation frames per plant type
- ADDR_W, 13: sprite ROM address width

Ports:
- Clk  in  1  pixel clock; single clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- de  in  1  display-enable for DrawX/DrawY.
- frame_start  in  1  one-cycle pulse per video frame.
- anim_en  in  1  animation counter enable.
- cell_we  in  1  occupancy write strobe.
- cell_row  in  3  write row, 0–4.
- cell_col  in  4  write column, 0–8.
- cell_type  in  2  plant_type_t value to write.
- rom_addr  out  ADDR_W  registered sprite ROM address.
- rom_data  in  7  ROM palette index, one cycle after rom_addr.
- pixel_index  out  7  palette index to the palette block.
- pixel_opaque  out  1  1 = draw pixel_index, 0 = show background.

## Operation
- Lawn geometry:
  - 9 columns × 5 rows of 64×64 cells.
  - A pixel is in the grid when GRID_X0 ≤ DrawX < GRID_X0+576 and GRID_Y0 ≤ DrawY < GRID_Y0+320.
  - ox = DrawX−GRID_X0 and oy = DrawY−GRID_Y0 are 10-bit values.
  - col = ox[9:6], row = oy[8:6].
- Sprites are 32×32, displayed at 2× scale: sx = ox[5:1], sy = oy[5:1].
- Address rule: rom_addr = ((type−1)·NUM_FRAMES + frame)·1024 + sy·32 + sx, truncated to ADDR_W.
  - type 0 (EMPTY) or a pixel outside the grid gives rom_addr = 0 and the hit bit cleared.
- Opaque rule: pixel_opaque = hit & (rom_data ≠ 0).
  - Index 0 is the transparent key.
  - When pixel_opaque = 0, pixel_index = 0.
  - de = 0 clears hit.
- Occupancy map: 45 × 2-bit registers.
  - A write with cell_row ≥ 5 or cell_col ≥ 9 is ignored.
  - A write becomes visible to the fetch path on the following cycle; a same-cycle read returns the old value.
- Animation counter:
  - div_cnt counts 0..ANIM_DIV−1 and advances only on frame_start with anim_en = 1.
  - When frame_start arrives at ANIM_DIV−1, div_cnt goes to 0 and frame goes to (frame+1) mod NUM_FRAMES.
  - frame changes only on frame_start, so no frame tears mid-picture.
- Reset (asynchronous, any time):
  - all cells → EMPTY; div_cnt, frame → 0.
  - rom_addr, pixel_index, pixel_opaque, and the pipeline hit bits → 0.
  - Reset in the middle of a line drops any in-flight pixels.

## Timing
- Pipeline latency is fixed at 3 cycles, with no stalls:
  - cycle n: DrawX/DrawY/de sampled; cell lookup and address computed combinationally.
  - cycle n+1: rom_addr and hit_d1 registered.
  - cycle n+2: rom_data valid; hit_d2.
  - cycle n+3: pixel_index and pixel_opaque registered.
- Throughput: one pixel per cycle.
- The compositor delays DrawX/DrawY by 3 cycles for alignment.
- frame_start and cell_we in the same cycle are independent; both take effect.

## Structure
- Shared package plants_pkg holds:
  - plant_type_t enum: EMPTY = 0, PEASHOOTER = 1, SUNFLOWER = 2, WALLNUT = 3.
  - Constants GRID_COLS = 9, GRID_ROWS = 5, CELL_SHIFT = 6, SPRITE_W = 32, TRANSPARENT_INDEX = 0.
- One sub-module, lawn_grid_regs, implements the occupancy register array: write port plus combinational read by row/col.
- Fetch pipeline and animation counter live in the top level.

## Test plan
The ROM model is synchronous and returns addr[6:0], or returns 0 where forced.
- Reset, then write (0,0) = PEASHOOTER.
  - DrawX = 40, 41, 42 at DrawY = 80 with de = 1 → rom_addr = 0, 0, 1 at n+1.
  - pixel_index = 0, 0, 1 at n+3; opaque = 0, 0, 1 (index 0 is transparent).
- Write (1,2) = SUNFLOWER; drive DrawX = 178, DrawY = 164.
  - → rom_addr = 2373 (0x945); pixel_index = 0x45, opaque = 1, exactly 3 cycles later.
- Animation: with anim_en = 1, pulse frame_start 15 times, then repeat the previous pixel.
  - → rom_addr = 3397.
  - After 30 pulses → 2373.
  - With anim_en = 0, pulses do not change frame.
- Boundaries, with row 0 cols 0–8 all PEASHOOTER:
  - DrawX = 615 → hit.
  - DrawX = 616, 39, and DrawY = 400 → opaque = 0, index = 0, rom_addr = 0.
  - de = 0 inside the grid → opaque = 0.
- Writes:
  - Write row = 5 or col = 9 → no cell changes; readback sweep shows EMPTY.
  - Write (0,0) = EMPTY in the same cycle the pixel at (40,80) is sampled → that pixel uses the old type; the next pixel shows opaque = 0.
- Assert Reset_n low mid-line for 1 cycle → all outputs 0 immediately, all cells EMPTY, frame = 0.

Source files
------------

// File: rtl/plants_pkg.sv
// Shared plant types, lawn geometry constants and the sprite-sheet addressing helper.
package plants_pkg;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    PEASHOOTER = 2'd1,
    SUNFLOWER  = 2'd2,
    WALLNUT    = 2'd3
  } plant_type_t;

  localparam int GRID_COLS  = 9;
  localparam int GRID_ROWS  = 5;
  localparam int CELL_SHIFT = 6;
  localparam int SPRITE_W   = 32;
  localparam logic [6:0] TRANSPARENT_INDEX = 7'd0;

  // Sheet layout: one 32x32 block per (type, frame); EMPTY has no block, hence type-1.
  function automatic int sprite_addr(input int ptype, input int frame, input int num_frames,
                                     input int sx, input int sy);
    return ((ptype - 1) * num_frames + frame) * (SPRITE_W * SPRITE_W) + sy * SPRITE_W + sx;
  endfunction

endpackage

// File: rtl/lawn_grid_regs.sv
// 5x9 lawn occupancy map: one write port, one combinational read port by row/col.
module lawn_grid_regs
  import plants_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [2:0]  wr_row_i,
  input  logic [3:0]  wr_col_i,
  input  plant_type_t wr_type_i,
  input  logic [2:0]  rd_row_i,
  input  logic [3:0]  rd_col_i,
  output plant_type_t rd_type_o
);

  plant_type_t cells_q [GRID_ROWS][GRID_COLS];
  plant_type_t cells_d [GRID_ROWS][GRID_COLS];

  // Next-state: only an in-range row/col matches a cell, so out-of-range writes fall through.
  always_comb begin
    cells_d = cells_q;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (we_i && (wr_row_i == 3'(r)) && (wr_col_i == 4'(c))) begin
          cells_d[r][c] = wr_type_i;
        end
      end
    end
  end

  // Occupancy state; every cell clears to EMPTY on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < GRID_ROWS; r++) begin
        for (int c = 0; c < GRID_COLS; c++) begin
          cells_q[r][c] <= EMPTY;
        end
      end
    end else begin
      cells_q <= cells_d;
    end
  end

  // Read returns the registered value, so a same-cycle write is not yet visible.
  always_comb begin
    rd_type_o = EMPTY;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if ((rd_row_i == 3'(r)) && (rd_col_i == 4'(c))) begin
          rd_type_o = cells_q[r][c];
        end
      end
    end
  end

endmodule

// File: rtl/plant_sprite_fetch.sv
// Per-pixel plant sprite fetch: cell lookup, sprite ROM addressing, transparency keying,
// plus the global plant animation-frame counter.
module plant_sprite_fetch
  import plants_pkg::*;
#(
  parameter int GRID_X0    = 40,
  parameter int GRID_Y0    = 80,
  parameter int ANIM_DIV   = 15,
  parameter int NUM_FRAMES = 2,
  parameter int ADDR_W     = 13
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              de,
  input  logic              frame_start,
  input  logic              anim_en,
  input  logic              cell_we,
  input  logic [2:0]        cell_row,
  input  logic [3:0]        cell_col,
  input  logic [1:0]        cell_type,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [6:0]        rom_data,
  output logic [6:0]        pixel_index,
  output logic              pixel_opaque
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [9:0]  X0   = 10'(GRID_X0);
  localparam logic [9:0]  Y0   = 10'(GRID_Y0);
  localparam logic [10:0] X_LO = 11'(GRID_X0);
  localparam logic [10:0] X_HI = 11'(GRID_X0 + (GRID_COLS << CELL_SHIFT));
  localparam logic [10:0] Y_LO = 11'(GRID_Y0);
  localparam logic [10:0] Y_HI = 11'(GRID_Y0 + (GRID_ROWS << CELL_SHIFT));

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Stage 0: coordinate decode, cell lookup and address generation (combinational)
  logic [9:0]  ox_p0, oy_p0;
  logic [3:0]  col_p0;
  logic [2:0]  row_p0;
  logic [4:0]  sx_p0, sy_p0;
  logic        in_grid_p0, hit_p0;
  plant_type_t type_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic        unused_bits_p0;

  assign ox_p0  = DrawX - X0;
  assign oy_p0  = DrawY - Y0;
  assign col_p0 = ox_p0[CELL_SHIFT+3:CELL_SHIFT];
  assign row_p0 = oy_p0[CELL_SHIFT+2:CELL_SHIFT];
  assign sx_p0  = ox_p0[CELL_SHIFT-1:1];
  assign sy_p0  = oy_p0[CELL_SHIFT-1:1];
  assign unused_bits_p0 = ^{ox_p0[0], oy_p0[0], oy_p0[9]};

  assign in_grid_p0 = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                      ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);

  lawn_grid_regs u_grid (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .we_i      (cell_we),
    .wr_row_i  (cell_row),
    .wr_col_i  (cell_col),
    .wr_type_i (plant_type_t'(cell_type)),
    .rd_row_i  (row_p0),
    .rd_col_i  (col_p0),
    .rd_type_o (type_p0)
  );

  // Hit gates the address so empty cells, blanking and off-lawn pixels all read address 0.
  always_comb begin
    hit_p0  = de && in_grid_p0 && (type_p0 != EMPTY);
    addr_p0 = '0;
    if (hit_p0) begin
      addr_p0 = ADDR_W'(sprite_addr(int'(type_p0), int'(frame_q), NUM_FRAMES,
                                    int'(sx_p0), int'(sy_p0)));
    end
  end

  // Stage 1..3 registers: ROM address, hit delay line, keyed palette index
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_p1_q, hit_p2_q;
  logic [6:0]        pixel_index_q, pixel_index_d;
  logic              pixel_opaque_q, pixel_opaque_d;

  // Transparency keying on the ROM word that returns for the stage-2 pixel.
  always_comb begin
    rom_addr_d     = addr_p0;
    pixel_opaque_d = hit_p2_q && (rom_data != TRANSPARENT_INDEX);
    pixel_index_d  = pixel_opaque_d ? rom_data : TRANSPARENT_INDEX;
  end

  // Fixed three-cycle pixel pipeline; reset flushes every in-flight pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q     <= '0;
      hit_p1_q       <= 1'b0;
      hit_p2_q       <= 1'b0;
      pixel_index_q  <= '0;
      pixel_opaque_q <= 1'b0;
    end else begin
      rom_addr_q     <= rom_addr_d;
      hit_p1_q       <= hit_p0;
      hit_p2_q       <= hit_p1_q;
      pixel_index_q  <= pixel_index_d;
      pixel_opaque_q <= pixel_opaque_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign pixel_index  = pixel_index_q;
  assign pixel_opaque = pixel_opaque_q;

  // Animation divider: only frame_start moves it, so a frame never changes mid-picture.
  always_comb begin
    div_cnt_d = div_cnt_q;
    frame_d   = frame_q;
    if (frame_start && anim_en) begin
      if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
        div_cnt_d = '0;
        frame_d   = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Animation state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_q <= '0;
      frame_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      frame_q   <= frame_d;
    end
  end

endmodule
